// File: rtl/register_file_sb.sv
// register_file_sb: integer register file with two combinational read ports,
// two synchronous write-back ports (wb0 = ALU, wb1 = LSU) and a per-register
// busy scoreboard used by decode to track outstanding producers.
// x0 reads as zero and is never written or marked busy. The stack pointer
// register is preset on reset.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write-back
// data (and the matching busy clear) onto the read ports.
module register_file_sb #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned SP_IDX    = 2,
  parameter logic [31:0] MEM_DEPTH = 32'h0001_0000,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h0100_0000 + MEM_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic              rs1_busy,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              wb0_en,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [XLEN-1:0]   wb0_data,
  input  logic              wb1_en,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [XLEN-1:0]   wb1_data
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                wb0_hit;
  logic                wb1_hit;
  logic                issue_fire;

  // Qualified write and claim strobes; x0 is excluded everywhere.
  assign wb0_hit    = wb0_en && (wb0_addr != '0);
  assign wb1_hit    = wb1_en && (wb1_addr != '0);
  assign issue_ready = (issue_rd == '0) || !busy[issue_rd];
  assign issue_fire = issue_valid && issue_ready && (issue_rd != '0);

  // Scoreboard next state: clears from either write port, then a same-cycle
  // claim re-sets the bit because the new producer is still outstanding.
  always_comb begin
    busy_nxt = busy;
    if (wb0_en) begin
      busy_nxt[wb0_addr] = 1'b0;
    end
    if (wb1_en) begin
      busy_nxt[wb1_addr] = 1'b0;
    end
    if (issue_fire) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Register array: reset preset, then wb0 followed by wb1 so wb1 wins a tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else begin
      if (wb0_hit) begin
        regs[wb0_addr] <= wb0_data;
      end
      if (wb1_hit) begin
        regs[wb1_addr] <= wb1_data;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Read port A, with optional same-cycle forwarding (wb1 has priority).
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs1_busy = busy[rs1_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb1_hit && (wb1_addr == rs1_addr)) begin
      rs1_data = wb1_data;
      rs1_busy = 1'b0;
    end else if (wb0_hit && (wb0_addr == rs1_addr)) begin
      rs1_data = wb0_data;
      rs1_busy = 1'b0;
    end
`endif
    if (rs1_addr == '0) begin
      rs1_data = '0;
      rs1_busy = 1'b0;
    end
  end

  // Read port B, same structure as port A.
  always_comb begin
    rs2_data = regs[rs2_addr];
    rs2_busy = busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb1_hit && (wb1_addr == rs2_addr)) begin
      rs2_data = wb1_data;
      rs2_busy = 1'b0;
    end else if (wb0_hit && (wb0_addr == rs2_addr)) begin
      rs2_data = wb0_data;
      rs2_busy = 1'b0;
    end
`endif
    if (rs2_addr == '0) begin
      rs2_data = '0;
      rs2_busy = 1'b0;
    end
  end

endmodule
